phy_reg_free_list: RTL and testbench
====================================

Name: phy_reg_free_list

Overview:
- Circular free list of physical scalar register numbers, sitting between the rename stage (allocator) and the commit stage (releaser).
- Rename pops up to POP_WIDTH free register numbers per cycle for destination allocation.
- Commit pushes up to PUSH_WIDTH released register numbers per cycle.
- At reset, holds every physical register not initially mapped to a logical register.

Parameters:
- ENTRY_NUM, 32, free-list depth (PSCALAR_NUM - LSCALAR_NUM); power of two.
- ENTRY_WIDTH, 6, width of one physical register number (PSCALAR_NUM_BIT_WIDTH).
- INIT_BASE, 32, first register number loaded at reset (LSCALAR_NUM).
- POP_WIDTH, 2, allocation lanes (RENAME_WIDTH).
- PUSH_WIDTH, 2, release lanes (COMMIT_WIDTH).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pop  in  POP_WIDTH  per-lane allocate request mask
- popRegNum  out  POP_WIDTH*ENTRY_WIDTH  allocated register number per lane (lane k at bits [k*ENTRY_WIDTH +: ENTRY_WIDTH])
- push  in  PUSH_WIDTH  per-lane release mask
- pushRegNum  in  PUSH_WIDTH*ENTRY_WIDTH  released register number per lane
- allocatable  out  1  count >= POP_WIDTH; rename may issue a full group
- count  out  $clog2(ENTRY_NUM)+1  number of free entries
- error  out  1  sticky underflow/overflow flag

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- State: entry array, headPtr and tailPtr ($clog2(ENTRY_NUM) bits each, wrap modulo ENTRY_NUM), count register, error register.
- Reset (rst high at a clk edge), effective the next cycle:
  - entries[i] = INIT_BASE + i
  - headPtr = 0, tailPtr = 0
  - count = ENTRY_NUM, allocatable = 1, error = 0
- Reset mid-operation discards all in-flight pushes and pops in that cycle and restores exactly this state.
- Pop read is combinational, zero latency, no bubble between consecutive pop cycles:
  - rank(k) = number of set pop bits in lanes below k.
  - popRegNum lane k = entries[(headPtr + rank(k)) mod ENTRY_NUM].
  - Value is presented regardless of pop[k]; it is meaningful only when pop[k]=1 and no underflow occurs.
  - Example: pop=2'b10 gives lane 1 the head entry.
- Pop update: headPtr += popcount(pop) at the clk edge.
- Push update: entries[(tailPtr + prank(k)) mod ENTRY_NUM] = pushRegNum lane k, where prank is the push-mask rank. Then tailPtr += popcount(push).
- Count update: count_next = count - popcount(pop) + popcount(push).
- Simultaneous push and pop are both applied in the same cycle.
- No bypass: an entry pushed in cycle t is poppable no earlier than cycle t+1, even when count=0.
- Underflow: popcount(pop) > count.
  - The entire pop group is ignored: headPtr unchanged.
  - The push group in the same cycle still applies.
  - error set to 1.
- Overflow: count - (applied pops) + popcount(push) > ENTRY_NUM.
  - The entire push group is ignored: tailPtr unchanged.
  - Pops still apply.
  - error set to 1.
- error clears only on rst.
- Wrap-around: both pointers and the per-lane indices wrap modulo ENTRY_NUM; a group may straddle the wrap point.
- Full (count=ENTRY_NUM) and empty (count=0) are distinguished by count, never by pointer equality.
- allocatable is combinational from the count register.

Test Plan:
- Reset, then pop=2'b11 for one cycle -> popRegNum lanes 0/1 = 32/33 that cycle; next cycle count=30, lanes show 34/35.
- Pop 2'b11 for 16 consecutive cycles -> all of 32..63 handed out in order, once each; count reaches 0; allocatable=0 once count<2; error=0.
- From empty, push 2'b11 with {40,41} while pop=2'b01 -> pop ignored, error=1, count=2; next cycle pop=2'b11 yields 40,41.
- Sparse masks: pop=2'b10 after reset -> lane 1 gets 32; push=2'b10 with lane1=50 at count=31 -> count=32 and 50 lands at the old tailPtr.
- Wrap: pop 31 entries, push 30 back (pops and pushes interleaved), then pop across index 31->0 -> order preserved; count matches a reference model every cycle.
- Assert rst mid-stream with push and pop active -> next cycle count=32, lanes 32/33, error=0; the pushed value is not retained.

Source files
------------

// File: rtl/phy_reg_free_list.sv
// Circular free list of physical register numbers between rename (pops) and commit (pushes).
// Multi-lane pop/push with compacted lane ranks, sticky underflow/overflow error.
module phy_reg_free_list #(
    parameter int ENTRY_NUM   = 32,
    parameter int ENTRY_WIDTH = 6,
    parameter int INIT_BASE   = 32,
    parameter int POP_WIDTH   = 2,
    parameter int PUSH_WIDTH  = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [POP_WIDTH-1:0]              pop,
    output logic [POP_WIDTH*ENTRY_WIDTH-1:0]  popRegNum,
    input  logic [PUSH_WIDTH-1:0]             push,
    input  logic [PUSH_WIDTH*ENTRY_WIDTH-1:0] pushRegNum,
    output logic                              allocatable,
    output logic [$clog2(ENTRY_NUM):0]        count,
    output logic                              error
);

    localparam int PTR_W = $clog2(ENTRY_NUM);
    localparam int CNT_W = PTR_W + 1;

    logic [ENTRY_WIDTH-1:0] entries [ENTRY_NUM];
    logic [PTR_W-1:0]       headPtr;
    logic [PTR_W-1:0]       tailPtr;
    logic [CNT_W-1:0]       countReg;
    logic                   errorReg;

    logic [CNT_W-1:0]       popRank  [POP_WIDTH];
    logic [CNT_W-1:0]       pushRank [PUSH_WIDTH];
    logic [PTR_W-1:0]       popIdx   [POP_WIDTH];
    logic [PTR_W-1:0]       pushIdx  [PUSH_WIDTH];
    logic [CNT_W-1:0]       popTotal;
    logic [CNT_W-1:0]       pushTotal;
    logic [CNT_W-1:0]       appliedPop;
    logic [CNT_W-1:0]       appliedPush;
    logic [CNT_W:0]         afterOps;
    logic                   underflow;
    logic                   overflow;

    // Each active lane takes the slot after those of the active lanes below it,
    // so sparse masks still consume consecutive entries.
    always_comb begin
        popTotal = '0;
        for (int k = 0; k < POP_WIDTH; k++) begin
            popRank[k] = popTotal;
            popIdx[k]  = headPtr + PTR_W'(popTotal);
            popTotal   = popTotal + CNT_W'(pop[k]);
        end
    end

    always_comb begin
        pushTotal = '0;
        for (int k = 0; k < PUSH_WIDTH; k++) begin
            pushRank[k] = pushTotal;
            pushIdx[k]  = tailPtr + PTR_W'(pushTotal);
            pushTotal   = pushTotal + CNT_W'(push[k]);
        end
    end

    always_comb begin
        popRegNum = '0;
        for (int k = 0; k < POP_WIDTH; k++) begin
            popRegNum[k*ENTRY_WIDTH +: ENTRY_WIDTH] = entries[popIdx[k]];
        end
    end

    // Overflow is judged after the pops that really happen, so a full list can
    // still accept releases in a cycle where rename drains it.
    always_comb begin
        underflow   = popTotal > countReg;
        appliedPop  = underflow ? '0 : popTotal;
        afterOps    = {1'b0, countReg} - {1'b0, appliedPop} + {1'b0, pushTotal};
        overflow    = afterOps > (CNT_W+1)'(ENTRY_NUM);
        appliedPush = overflow ? '0 : pushTotal;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                entries[i] <= ENTRY_WIDTH'(INIT_BASE + i);
            end
            headPtr  <= '0;
            tailPtr  <= '0;
            countReg <= CNT_W'(ENTRY_NUM);
            errorReg <= 1'b0;
        end else begin
            if (!overflow) begin
                for (int k = 0; k < PUSH_WIDTH; k++) begin
                    if (push[k]) begin
                        entries[pushIdx[k]] <= pushRegNum[k*ENTRY_WIDTH +: ENTRY_WIDTH];
                    end
                end
            end
            headPtr  <= headPtr + PTR_W'(appliedPop);
            tailPtr  <= tailPtr + PTR_W'(appliedPush);
            countReg <= countReg - appliedPop + appliedPush;
            if (underflow || overflow) begin
                errorReg <= 1'b1;
            end
        end
    end

    assign count       = countReg;
    assign error       = errorReg;
    assign allocatable = countReg >= CNT_W'(POP_WIDTH);

endmodule

// File: tb/tb_phy_reg_free_list.sv
// Directed self-checking bench for phy_reg_free_list: reset image, draining,
// underflow/overflow, sparse lanes, wrap-around against a queue model, mid-stream reset.
module tb_phy_reg_free_list;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  pop = 2'b00;
    logic [1:0]  push = 2'b00;
    logic [11:0] pushRegNum = '0;
    logic [11:0] popRegNum;
    logic        allocatable;
    logic [5:0]  count;
    logic        error;
    logic [5:0]  lane0;
    logic [5:0]  lane1;

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    phy_reg_free_list #(
        .ENTRY_NUM(32), .ENTRY_WIDTH(6), .INIT_BASE(32), .POP_WIDTH(2), .PUSH_WIDTH(2)
    ) dut (
        .clk(clk), .rst(rst), .pop(pop), .popRegNum(popRegNum), .push(push),
        .pushRegNum(pushRegNum), .allocatable(allocatable), .count(count), .error(error)
    );

    assign lane0 = popRegNum[5:0];
    assign lane1 = popRegNum[11:6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1; pop = 2'b00; push = 2'b00; pushRegNum = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        checkCount++; if (count !== 6'd32) $display("[TB] FAIL reset_count: got %0d expected 32", count); else passCount++;
        checkCount++; if (allocatable !== 1'b1) $display("[TB] FAIL reset_alloc: got %b expected 1", allocatable); else passCount++;
        checkCount++; if (error !== 1'b0) $display("[TB] FAIL reset_error: got %b expected 0", error); else passCount++;
    endtask

    task automatic test_pop_pair();
        doReset();
        pop = 2'b11; #1;
        checkCount++; if (lane0 !== 6'd32) $display("[TB] FAIL pair_lane0: got %0d expected 32", lane0); else passCount++;
        checkCount++; if (lane1 !== 6'd33) $display("[TB] FAIL pair_lane1: got %0d expected 33", lane1); else passCount++;
        step();
        checkCount++; if (count !== 6'd30) $display("[TB] FAIL pair_count: got %0d expected 30", count); else passCount++;
        checkCount++; if (lane0 !== 6'd34) $display("[TB] FAIL pair_next0: got %0d expected 34", lane0); else passCount++;
        checkCount++; if (lane1 !== 6'd35) $display("[TB] FAIL pair_next1: got %0d expected 35", lane1); else passCount++;
        pop = 2'b00;
    endtask

    task automatic test_drain();
        doReset();
        pop = 2'b11;
        for (int c = 0; c < 16; c++) begin
            #1;
            checkCount++; if (lane0 !== 6'(32 + 2*c)) $display("[TB] FAIL drain_lane0[%0d]: got %0d expected %0d", c, lane0, 32 + 2*c); else passCount++;
            checkCount++; if (lane1 !== 6'(33 + 2*c)) $display("[TB] FAIL drain_lane1[%0d]: got %0d expected %0d", c, lane1, 33 + 2*c); else passCount++;
            step();
            checkCount++; if (count !== 6'(30 - 2*c)) $display("[TB] FAIL drain_count[%0d]: got %0d expected %0d", c, count, 30 - 2*c); else passCount++;
            checkCount++; if (allocatable !== ((30 - 2*c) >= 2)) $display("[TB] FAIL drain_alloc[%0d]: got %b expected %b", c, allocatable, ((30 - 2*c) >= 2)); else passCount++;
        end
        pop = 2'b00;
        checkCount++; if (error !== 1'b0) $display("[TB] FAIL drain_error: got %b expected 0", error); else passCount++;
    endtask

    // Runs straight after test_drain, so the list is empty with both pointers at 0.
    task automatic test_underflow_push();
        push = 2'b11; pushRegNum = {6'd41, 6'd40}; pop = 2'b01;
        step();
        push = 2'b00; pop = 2'b00;
        checkCount++; if (error !== 1'b1) $display("[TB] FAIL uflow_error: got %b expected 1", error); else passCount++;
        checkCount++; if (count !== 6'd2) $display("[TB] FAIL uflow_count: got %0d expected 2", count); else passCount++;
        pop = 2'b11; #1;
        checkCount++; if (lane0 !== 6'd40) $display("[TB] FAIL uflow_lane0: got %0d expected 40", lane0); else passCount++;
        checkCount++; if (lane1 !== 6'd41) $display("[TB] FAIL uflow_lane1: got %0d expected 41", lane1); else passCount++;
        step();
        pop = 2'b00;
        checkCount++; if (count !== 6'd0) $display("[TB] FAIL uflow_drained: got %0d expected 0", count); else passCount++;
        checkCount++; if (error !== 1'b1) $display("[TB] FAIL uflow_sticky: got %b expected 1", error); else passCount++;
    endtask

    task automatic test_sparse();
        doReset();
        pop = 2'b10; #1;
        checkCount++; if (lane1 !== 6'd32) $display("[TB] FAIL sparse_lane1: got %0d expected 32", lane1); else passCount++;
        step();
        pop = 2'b00;
        checkCount++; if (count !== 6'd31) $display("[TB] FAIL sparse_count31: got %0d expected 31", count); else passCount++;
        push = 2'b10; pushRegNum = {6'd50, 6'd0};
        step();
        push = 2'b00;
        checkCount++; if (count !== 6'd32) $display("[TB] FAIL sparse_count32: got %0d expected 32", count); else passCount++;
        checkCount++; if (error !== 1'b0) $display("[TB] FAIL sparse_error: got %b expected 0", error); else passCount++;
        pop = 2'b11;
        for (int c = 0; c < 15; c++) begin
            #1;
            checkCount++; if (lane0 !== 6'(33 + 2*c)) $display("[TB] FAIL sparse_l0[%0d]: got %0d expected %0d", c, lane0, 33 + 2*c); else passCount++;
            checkCount++; if (lane1 !== 6'(34 + 2*c)) $display("[TB] FAIL sparse_l1[%0d]: got %0d expected %0d", c, lane1, 34 + 2*c); else passCount++;
            step();
        end
        pop = 2'b01; #1;
        checkCount++; if (lane0 !== 6'd63) $display("[TB] FAIL sparse_last: got %0d expected 63", lane0); else passCount++;
        step();
        #1;
        checkCount++; if (lane0 !== 6'd50) $display("[TB] FAIL sparse_pushed: got %0d expected 50", lane0); else passCount++;
        step();
        pop = 2'b00;
        checkCount++; if (count !== 6'd0) $display("[TB] FAIL sparse_empty: got %0d expected 0", count); else passCount++;
    endtask

    task automatic test_overflow();
        doReset();
        push = 2'b11; pushRegNum = {6'd8, 6'd7};
        step();
        push = 2'b00;
        checkCount++; if (error !== 1'b1) $display("[TB] FAIL oflow_error: got %b expected 1", error); else passCount++;
        checkCount++; if (count !== 6'd32) $display("[TB] FAIL oflow_count: got %0d expected 32", count); else passCount++;
        pop = 2'b11; #1;
        checkCount++; if (lane0 !== 6'd32) $display("[TB] FAIL oflow_lane0: got %0d expected 32", lane0); else passCount++;
        checkCount++; if (lane1 !== 6'd33) $display("[TB] FAIL oflow_lane1: got %0d expected 33", lane1); else passCount++;
        step();
        pop = 2'b00;
        checkCount++; if (count !== 6'd30) $display("[TB] FAIL oflow_after: got %0d expected 30", count); else passCount++;
        // Full list with a simultaneous pop/push pair stays legal.
        doReset();
        pop = 2'b11; push = 2'b11; pushRegNum = {6'd10, 6'd9};
        step();
        pop = 2'b00; push = 2'b00;
        checkCount++; if (error !== 1'b0) $display("[TB] FAIL fullswap_error: got %b expected 0", error); else passCount++;
        checkCount++; if (count !== 6'd32) $display("[TB] FAIL fullswap_count: got %0d expected 32", count); else passCount++;
    endtask

    task automatic test_wrap();
        int q[$];
        int p0, p1, n0, n1;
        logic [1:0] mask;
        doReset();
        for (int i = 0; i < 32; i++) q.push_back(32 + i);
        p0 = 0; p1 = 0;
        for (int c = 0; c < 16; c++) begin
            mask = (c < 15) ? 2'b11 : 2'b01;
            pop = mask;
            push = (c >= 1) ? 2'b11 : 2'b00;
            pushRegNum = {6'(p1), 6'(p0)};
            #1;
            checkCount++; if (lane0 !== 6'(q[0])) $display("[TB] FAIL wrap_l0[%0d]: got %0d expected %0d", c, lane0, q[0]); else passCount++;
            if (mask == 2'b11) begin
                checkCount++; if (lane1 !== 6'(q[1])) $display("[TB] FAIL wrap_l1[%0d]: got %0d expected %0d", c, lane1, q[1]); else passCount++;
            end
            n0 = q.pop_front();
            n1 = 0;
            if (mask == 2'b11) n1 = q.pop_front();
            if (c >= 1) begin
                q.push_back(p0);
                q.push_back(p1);
            end
            step();
            checkCount++; if (count !== 6'(q.size())) $display("[TB] FAIL wrap_count[%0d]: got %0d expected %0d", c, count, q.size()); else passCount++;
            p0 = n0; p1 = n1;
        end
        push = 2'b00;
        for (int i = 0; i < 40 && q.size() > 0; i++) begin
            mask = (q.size() >= 2) ? 2'b11 : 2'b01;
            pop = mask;
            #1;
            checkCount++; if (lane0 !== 6'(q[0])) $display("[TB] FAIL wrapdrain_l0[%0d]: got %0d expected %0d", i, lane0, q[0]); else passCount++;
            if (mask == 2'b11) begin
                checkCount++; if (lane1 !== 6'(q[1])) $display("[TB] FAIL wrapdrain_l1[%0d]: got %0d expected %0d", i, lane1, q[1]); else passCount++;
            end
            n0 = q.pop_front();
            if (mask == 2'b11) n1 = q.pop_front();
            step();
            checkCount++; if (count !== 6'(q.size())) $display("[TB] FAIL wrapdrain_count[%0d]: got %0d expected %0d", i, count, q.size()); else passCount++;
        end
        pop = 2'b00;
        checkCount++; if (error !== 1'b0) $display("[TB] FAIL wrap_error: got %b expected 0", error); else passCount++;
    endtask

    task automatic test_reset_mid();
        doReset();
        push = 2'b11; pushRegNum = {6'd2, 6'd1};
        step();
        push = 2'b00;
        checkCount++; if (error !== 1'b1) $display("[TB] FAIL mid_preerror: got %b expected 1", error); else passCount++;
        pop = 2'b11;
        step(); step(); step();
        checkCount++; if (count !== 6'd26) $display("[TB] FAIL mid_precount: got %0d expected 26", count); else passCount++;
        rst = 1'b1; pop = 2'b11; push = 2'b11; pushRegNum = {6'd56, 6'd55};
        step();
        rst = 1'b0; push = 2'b00; pop = 2'b11;
        checkCount++; if (count !== 6'd32) $display("[TB] FAIL mid_count: got %0d expected 32", count); else passCount++;
        checkCount++; if (error !== 1'b0) $display("[TB] FAIL mid_error: got %b expected 0", error); else passCount++;
        checkCount++; if (allocatable !== 1'b1) $display("[TB] FAIL mid_alloc: got %b expected 1", allocatable); else passCount++;
        for (int c = 0; c < 16; c++) begin
            #1;
            checkCount++; if (lane0 !== 6'(32 + 2*c)) $display("[TB] FAIL mid_l0[%0d]: got %0d expected %0d", c, lane0, 32 + 2*c); else passCount++;
            checkCount++; if (lane1 !== 6'(33 + 2*c)) $display("[TB] FAIL mid_l1[%0d]: got %0d expected %0d", c, lane1, 33 + 2*c); else passCount++;
            step();
        end
        pop = 2'b00;
        checkCount++; if (count !== 6'd0) $display("[TB] FAIL mid_empty: got %0d expected 0", count); else passCount++;
    endtask

    initial begin
        test_reset();
        test_pop_pair();
        test_drain();
        test_underflow_push();
        test_sparse();
        test_overflow();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
